cache_req_queue: RTL and testbench

//  Upstream request buffer for cache_top. Accepts CPU load/store requests on a valid/ready

---
 rtl/cache_req_queue.sv | 181 ++++++++++++++++++
 tb/tb_cache_req_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_queue.sv
// Request buffer in front of cache_top: DEPTH-entry FIFO, one outstanding request, in-order responses.
// Optional response timeout in WAIT is enabled by defining CACHE_REQ_TIMEOUT_EN.
module cache_req_queue #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          cclk,
    input  logic          creset,
    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic [AW-1:0] cpu_req_address,
    input  logic [1:0]    cpu_req_op,
    input  logic [DW-1:0] cpu_req_wdata,
    output logic          cpu_resp_valid,
    output logic [1:0]    cpu_resp_op,
    output logic [DW-1:0] cpu_resp_rdata,
    output logic          cpu_resp_status,
    output logic          req_valid,
    output logic [AW-1:0] req_address,
    output logic [1:0]    req_op,
    output logic [DW-1:0] req_wdata,
    input  logic          resp_valid,
    input  logic [DW-1:0] resp_rdata,
    input  logic          resp_status
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_WR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [DW-1:0] wdata;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          req_valid_q, req_valid_d;
    entry_t        req_q, req_d;
    logic          resp_valid_q, resp_valid_d;
    logic [1:0]    resp_op_q, resp_op_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          resp_status_q, resp_status_d;
    logic          push, pop, head_legal;
    entry_t        head;
`ifdef CACHE_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign cpu_req_ready = (count_q != CW'(DEPTH));
    assign push          = cpu_req_valid && cpu_req_ready;
    assign head          = mem_q[rd_ptr_q];
    assign head_legal    = (head.op == OP_RD) || (head.op == OP_WR);

    // NOTE: payload storage has no reset; an entry is only read once count says it was written.
    always_ff @(posedge cclk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: cpu_req_address, op: cpu_req_op, wdata: cpu_req_wdata};
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d       = count_q;
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_d         = req_q;
        resp_valid_d  = 1'b0;
        resp_op_d     = resp_op_q;
        resp_rdata_d  = resp_rdata_q;
        resp_status_d = resp_status_q;
        pop           = 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
        tmo_d = (state_q == S_WAIT) ? tmo_q + TW'(1) : '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    if (head_legal) begin
                        state_d     = S_ISSUE;
                        req_valid_d = 1'b1;
                        req_d       = head;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            // A completion arriving while the request is first presented is not lost.
            S_ISSUE, S_WAIT: begin
                if (state_q == S_ISSUE) state_d = S_WAIT;
                if (resp_valid) begin
                    pop           = 1'b1;
                    req_valid_d   = 1'b0;
                    state_d       = S_IDLE;
                    resp_valid_d  = 1'b1;
                    resp_op_d     = req_q.op;
                    resp_rdata_d  = (req_q.op == OP_RD) ? resp_rdata : '0;
                    resp_status_d = resp_status;
                end
`ifdef CACHE_REQ_TIMEOUT_EN
                else if (state_q == S_WAIT && tmo_q == TW'(TIMEOUT - 1)) begin
                    pop           = 1'b1;
                    req_valid_d   = 1'b0;
                    state_d       = S_IDLE;
                    resp_valid_d  = 1'b1;
                    resp_op_d     = req_q.op;
                    resp_rdata_d  = '0;
                    resp_status_d = 1'b1;
                end
`endif
            end
            S_ERR: begin
                pop           = 1'b1;
                state_d       = S_IDLE;
                resp_valid_d  = 1'b1;
                resp_op_d     = head.op;
                resp_rdata_d  = '0;
                resp_status_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge cclk or posedge creset) begin
        if (creset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            req_valid_q   <= 1'b0;
            req_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_op_q     <= '0;
            resp_rdata_q  <= '0;
            resp_status_q <= 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_q         <= req_d;
            resp_valid_q  <= resp_valid_d;
            resp_op_q     <= resp_op_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_status_q <= resp_status_d;
`ifdef CACHE_REQ_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign req_valid       = req_valid_q;
    assign req_address     = req_q.addr;
    assign req_op          = req_q.op;
    assign req_wdata       = req_q.wdata;
    assign cpu_resp_valid  = resp_valid_q;
    assign cpu_resp_op     = resp_op_q;
    assign cpu_resp_rdata  = resp_rdata_q;
    assign cpu_resp_status = resp_status_q;
endmodule

// File: tb/tb_cache_req_queue.sv
// Bench for cache_req_queue: transaction-level scoreboard checked every cycle plus directed timing checks.
module tb_cache_req_queue;
    localparam int DEPTH = 4, AW = 32, DW = 32, TIMEOUT = 16;

    logic          cclk = 1'b0, creset = 1'b1;
    logic          cpu_req_valid = 1'b0, cpu_req_ready;
    logic [AW-1:0] cpu_req_address = '0;
    logic [1:0]    cpu_req_op = '0;
    logic [DW-1:0] cpu_req_wdata = '0;
    logic          cpu_resp_valid, cpu_resp_status;
    logic [1:0]    cpu_resp_op;
    logic [DW-1:0] cpu_resp_rdata;
    logic          req_valid;
    logic [AW-1:0] req_address;
    logic [1:0]    req_op;
    logic [DW-1:0] req_wdata;
    logic          resp_valid = 1'b0, resp_status = 1'b0;
    logic [DW-1:0] resp_rdata = '0;

    cache_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .cclk(cclk), .creset(creset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_address(cpu_req_address), .cpu_req_op(cpu_req_op), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_op(cpu_resp_op),
        .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_status(cpu_resp_status),
        .req_valid(req_valid), .req_address(req_address), .req_op(req_op), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_status(resp_status)
    );

    always #5 cclk = ~cclk;

    typedef struct { logic [AW-1:0] addr; logic [1:0] op; logic [DW-1:0] wdata; } req_t;
    typedef struct { logic [1:0] op; logic [DW-1:0] rdata; logic status; } rsp_t;

    req_t          mq[$];
    rsp_t          log_q[$];
    req_t          front_m;
    rsp_t          exp_m;
    bit            exp_prev = 1'b0, do_cmp;
    logic [DW-1:0] given_rdata = '0;
    logic          given_status = 1'b0;
    int            n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit legal(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    // Scoreboard: requests leave in push order; each answer is derived from the request and the cache reply.
    always @(negedge cclk) begin
        if (creset) begin
            mq.delete();
            exp_prev = 1'b0;
        end else begin
            if (exp_prev) check("resp_follows_cache", cpu_resp_valid, 1);
            if (cpu_resp_valid) begin
                if (mq.size() == 0) begin
                    check("resp_with_empty_queue", cpu_resp_valid, 0);
                end else begin
                    front_m = mq.pop_front();
                    do_cmp  = 1'b1;
                    if (!legal(front_m.op)) exp_m = '{front_m.op, '0, 1'b1};
                    else if (exp_prev)
                        exp_m = '{front_m.op, (front_m.op == 2'b01) ? given_rdata : '0, given_status};
                    else begin
`ifdef CACHE_REQ_TIMEOUT_EN
                        exp_m = '{front_m.op, '0, 1'b1};
`else
                        check("resp_unsolicited", cpu_resp_valid, 0);
                        do_cmp = 1'b0;
`endif
                    end
                    if (do_cmp) begin
                        check("resp_op", cpu_resp_op, exp_m.op);
                        check("resp_rdata", cpu_resp_rdata, exp_m.rdata);
                        check("resp_status", cpu_resp_status, exp_m.status);
                    end
                end
                log_q.push_back('{cpu_resp_op, cpu_resp_rdata, cpu_resp_status});
            end
            check("ready", cpu_req_ready, mq.size() < DEPTH);
            if (req_valid) begin
                if (mq.size() == 0) check("req_with_empty_queue", req_valid, 0);
                else begin
                    check("req_address", req_address, mq[0].addr);
                    check("req_op", req_op, mq[0].op);
                    check("req_wdata", req_wdata, mq[0].wdata);
                    check("req_op_legal", legal(req_op), 1);
                end
            end
            exp_prev     = resp_valid && req_valid;
            given_rdata  = resp_rdata;
            given_status = resp_status;
            if (cpu_req_valid && mq.size() < DEPTH)
                mq.push_back('{cpu_req_address, cpu_req_op, cpu_req_wdata});
        end
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [1:0] op, input logic [DW-1:0] wd);
        bit done = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_address = a; cpu_req_op = op; cpu_req_wdata = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            done = cpu_req_ready;
            tick();
        end
        check("push_accepted", done, 1);
        cpu_req_valid = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [DW-1:0] rd, input logic st);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (req_valid) seen = 1'b1;
            else tick();
        end
        check("req_valid_seen", seen, 1);
        repeat (dly) tick();
        resp_valid = 1'b1; resp_rdata = rd; resp_status = st;
        tick();
        resp_valid = 1'b0; resp_status = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lb;
        repeat (2) tick();
        check("rst_ready", cpu_req_ready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_resp_valid", cpu_resp_valid, 0);
        check("rst_req_address", req_address, 0);
        check("rst_resp_rdata", cpu_resp_rdata, 0);
        creset = 1'b0;
        tick();

        // Single read: issue two cycles after push, answer one cycle after the cache.
        cpu_req_valid = 1'b1; cpu_req_address = 32'h100; cpu_req_op = 2'b01; cpu_req_wdata = '0;
        tick();
        cpu_req_valid = 1'b0;
        check("t1_req_n1", req_valid, 0);
        tick();
        check("t1_req_n2", req_valid, 1);
        check("t1_req_addr", req_address, 32'h100);
        check("t1_req_op", req_op, 2'b01);
        repeat (5) tick();
        resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF; resp_status = 1'b0;
        tick();
        resp_valid = 1'b0;
        check("t1_resp_valid", cpu_resp_valid, 1);
        check("t1_resp_op", cpu_resp_op, 2'b01);
        check("t1_resp_rdata", cpu_resp_rdata, 32'hDEAD_BEEF);
        check("t1_resp_status", cpu_resp_status, 0);
        check("t1_req_drop", req_valid, 0);
        tick();
        check("t1_resp_pulse", cpu_resp_valid, 0);

        // Fill with writes while the cache stalls; a fifth push waits for a free slot.
        lb = log_q.size();
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i * 4), 2'b10, 32'h1000 + 32'(i));
        check("t2_full", cpu_req_ready, 0);
        check("t2_first_issued", req_address, 32'h200);
        fork
            push(32'h210, 2'b10, 32'h1004);
            begin
                resp_valid = 1'b1; resp_rdata = 32'h1234_5678;
                tick();
                resp_valid = 1'b0;
                check("t2_req_drop", req_valid, 0);
                check("t2_resp_valid", cpu_resp_valid, 1);
                tick();
                check("t2_reissue", req_valid, 1);
                check("t2_reissue_addr", req_address, 32'h204);
                for (int i = 0; i < 4; i++) respond(i + 1, 32'h1234_5678, 1'b0);
            end
        join
        repeat (2) tick();
        check("t2_resp_count", log_q.size(), lb + 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_resp_op", log_q[lb+i].op, 2'b10);
            check("t2_resp_rdata", log_q[lb+i].rdata, 0);
        end

        // Illegal op between two reads is answered with an error and never reaches the cache.
        lb = log_q.size();
        push(32'h300, 2'b01, '0);
        push(32'h304, 2'b00, 32'hBAD);
        push(32'h308, 2'b01, '0);
        respond(1, 32'hA1, 1'b0);
        respond(2, 32'hA2, 1'b0);
        repeat (3) tick();
        check("t3_resp_count", log_q.size(), lb + 3);
        check("t3_r0_rdata", log_q[lb].rdata, 32'hA1);
        check("t3_r0_status", log_q[lb].status, 0);
        check("t3_r1_op", log_q[lb+1].op, 2'b00);
        check("t3_r1_rdata", log_q[lb+1].rdata, 0);
        check("t3_r1_status", log_q[lb+1].status, 1);
        check("t3_r2_rdata", log_q[lb+2].rdata, 32'hA2);
        check("t3_r2_status", log_q[lb+2].status, 0);

        // Reset while waiting with three queued: flush, no late response.
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i * 4), 2'b01, '0);
        repeat (2) tick();
        check("t4_waiting", req_valid, 1);
        lb = log_q.size();
        #2 creset = 1'b1;
        #1;
        check("t4_async_req_valid", req_valid, 0);
        check("t4_async_ready", cpu_req_ready, 1);
        tick();
        tick();
        creset = 1'b0;
        repeat (10) tick();
        check("t4_no_resp", log_q.size(), lb);
        check("t4_req_idle", req_valid, 0);
        check("t4_ready", cpu_req_ready, 1);

        // Stray completion while idle is ignored; the next read still behaves normally.
        lb = log_q.size();
        resp_valid = 1'b1; resp_rdata = 32'hFFFF; resp_status = 1'b1;
        tick();
        resp_valid = 1'b0; resp_status = 1'b0;
        repeat (3) tick();
        check("t5_no_resp", log_q.size(), lb);
        check("t5_req_idle", req_valid, 0);
        cpu_req_valid = 1'b1; cpu_req_address = 32'h500; cpu_req_op = 2'b01;
        tick();
        cpu_req_valid = 1'b0;
        check("t5_req_n1", req_valid, 0);
        tick();
        check("t5_req_n2", req_valid, 1);
        respond(1, 32'h55, 1'b1);
        tick();
        check("t5_resp_count", log_q.size(), lb + 1);
        check("t5_resp_rdata", log_q[lb].rdata, 32'h55);
        check("t5_resp_status", log_q[lb].status, 1);

`ifdef CACHE_REQ_TIMEOUT_EN
        // Withheld completion: error response 16 cycles after the wait begins, then next head issues.
        cpu_req_valid = 1'b1; cpu_req_address = 32'h600; cpu_req_op = 2'b01; cpu_req_wdata = '0;
        tick();
        cpu_req_address = 32'h604; cpu_req_op = 2'b10; cpu_req_wdata = 32'h77;
        tick();
        cpu_req_valid = 1'b0;
        check("t6_issue", req_valid, 1);
        repeat (16) tick();
        check("t6_not_yet", cpu_resp_valid, 0);
        tick();
        check("t6_tmo_valid", cpu_resp_valid, 1);
        check("t6_tmo_status", cpu_resp_status, 1);
        check("t6_tmo_rdata", cpu_resp_rdata, 0);
        check("t6_tmo_drop", req_valid, 0);
        tick();
        check("t6_next_issue", req_valid, 1);
        check("t6_next_addr", req_address, 32'h604);
        respond(2, 32'h99, 1'b0);
        repeat (2) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
